// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: emits one 48-bit round subkey per accepted handshake,
// in K1..K16 order for encryption or K16..K1 order for decryption.
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [64:1] key_in,
    input  logic        decrypt,
    input  logic        start,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic [4:1]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    // Tables use DES numbering: entry i names the source bit of output bit i+1.
    localparam int PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
    function automatic logic shift_is_two(input logic [4:0] rnd);
        return !((rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16));
    endfunction

    function automatic logic [28:1] rot_left(input logic [28:1] v, input logic two);
        return two ? {v[26:1], v[28:27]} : {v[27:1], v[28]};
    endfunction

    function automatic logic [28:1] rot_right(input logic [28:1] v, input logic two);
        return two ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
    endfunction

    state_t      state_q, state_d;
    logic [28:1] c_q, c_d;
    logic [28:1] d_q, d_d;
    logic [3:0]  step_q, step_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;

    logic [56:1] pc1_key;
    logic [56:1] cd_cur;
    logic [48:1] pc2_out;
    logic        handshake;
    logic        unused_parity;

    // DES bit n of a [N:1] vector sits at index N+1-n.
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[56 - gi] = key_in[65 - PC1_TAB[gi]];
        end
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_out[48 - gi] = cd_cur[57 - PC2_TAB[gi]];
        end
    endgenerate

    assign unused_parity = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                             key_in[25], key_in[17], key_in[9],  key_in[1]};

    assign cd_cur    = {c_q, d_q};
    assign handshake = (state_q == ST_GEN) && subkey_ready;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        step_d  = step_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Decrypt starts from the unrotated halves: 28 total positions equals K16.
                    if (decrypt) begin
                        c_d = pc1_key[56:29];
                        d_d = pc1_key[28:1];
                    end else begin
                        c_d = rot_left(pc1_key[56:29], 1'b0);
                        d_d = rot_left(pc1_key[28:1], 1'b0);
                    end
                    dec_d   = decrypt;
                    step_d  = 4'd0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                if (handshake) begin
                    step_d = step_q + 4'd1;
                    if (step_q == 4'd15) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (dec_q) begin
                        c_d = rot_right(c_q, shift_is_two(5'd16 - {1'b0, step_q}));
                        d_d = rot_right(d_q, shift_is_two(5'd16 - {1'b0, step_q}));
                    end else begin
                        c_d = rot_left(c_q, shift_is_two({1'b0, step_q} + 5'd2));
                        d_d = rot_left(d_q, shift_is_two({1'b0, step_q} + 5'd2));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            step_q  <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign subkey_valid = (state_q == ST_GEN);
    assign busy         = (state_q == ST_GEN);
    assign done         = done_q;
    assign subkey       = pc2_out;
    assign round_idx    = dec_q ? (4'd15 - step_q) : step_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: known-answer table, reference model, stalls, resets, back-to-back.
module tb_des_key_scheduler;

    logic        clk;
    logic        rst_n;
    logic [64:1] key_in;
    logic        decrypt;
    logic        start;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [48:1] subkey;
    logic [4:1]  round_idx;
    logic        busy;
    logic        done;

    des_key_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .decrypt     (decrypt),
        .start       (start),
        .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready),
        .subkey      (subkey),
        .round_idx   (round_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    int PC1 [0:55] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                       10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                       14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int PC2 [0:47] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                       23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                       41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                       44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int READY_PAT [0:5] = '{1, 0, 0, 1, 0, 1};

    logic [47:0] ref_ks [16];
    logic [47:0] del_sk [16];
    logic [3:0]  del_ri [16];
    logic [47:0] enc_sk [16];
    logic [3:0]  enc_ri [16];
    logic [47:0] dec_sk [16];
    logic [3:0]  dec_ri [16];

    typedef struct {
        logic        dec;
        int          pos;
        logic [47:0] exp_sk;
        logic [3:0]  exp_ri;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Subkey i uses the halves rotated left by the cumulative shift through round i.
    task automatic model(input logic [63:0] key);
        logic c0 [28];
        logic d0 [28];
        logic cd [56];
        logic [47:0] sk;
        int tot;
        tot = 0;
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64 - PC1[i]];
            d0[i] = key[64 - PC1[28 + i]];
        end
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            for (int i = 0; i < 28; i++) begin
                cd[i]      = c0[(i + tot) % 28];
                cd[28 + i] = d0[(i + tot) % 28];
            end
            for (int j = 0; j < 48; j++) sk[47 - j] = cd[PC2[j] - 1];
            ref_ks[r] = sk;
        end
    endtask

    // Entered and left at a falling edge. ready_mode: 0 always, 1 fixed pattern, 2 random.
    task automatic run_sched(input logic [63:0] key, input logic dec, input int ready_mode,
                             input bit hold_start, input bit poke_start);
        int h;
        int cyc;
        bit have_prev;
        logic [47:0] prev_sk;
        logic [3:0] prev_ri;
        logic rdy;
        int exp_r;
        model(key);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        h = 0;
        cyc = 0;
        have_prev = 0;
        prev_sk = '0;
        prev_ri = '0;
        while (h < 16 && cyc < 400) begin
            check("valid_in_gen", {63'd0, subkey_valid}, 64'd1);
            check("busy_in_gen", {63'd0, busy}, 64'd1);
            check("no_done_in_gen", {63'd0, done}, 64'd0);
            if (have_prev) begin
                check("stall_subkey_hold", {16'd0, subkey}, {16'd0, prev_sk});
                check("stall_round_hold", {60'd0, round_idx}, {60'd0, prev_ri});
            end
            exp_r = dec ? 15 - h : h;
            check("round_idx", {60'd0, round_idx}, 64'(exp_r));
            check("subkey_vs_model", {16'd0, subkey}, {16'd0, ref_ks[exp_r]});
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = READY_PAT[cyc % 6] != 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (poke_start) begin
                start   = 1'b1;
                key_in  = {$urandom, $urandom};
                decrypt = ~dec;
            end
            subkey_ready = rdy;
            if (rdy) begin
                del_sk[h] = subkey;
                del_ri[h] = round_idx;
                h++;
                have_prev = 0;
            end else begin
                have_prev = 1;
                prev_sk = subkey;
                prev_ri = round_idx;
            end
            cyc++;
            @(negedge clk);
        end
        if (!hold_start) start = 1'b0;
        subkey_ready = 1'b1;
        check("handshake_count", 64'(h), 64'd16);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("valid_after_last", {63'd0, subkey_valid}, 64'd0);
        check("busy_after_last", {63'd0, busy}, 64'd0);
        $display("[TB] schedule key=%h dec=%0d ready_mode=%0d handshakes=%0d cycles=%0d",
                 key, dec, ready_mode, h, cyc);
        if (!hold_start) begin
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        int cyc;
        logic [63:0] rkey;
        logic rdec;

        vecs[0] = '{1'b0, 0,  48'h1B02EFFC7072, 4'd0};
        vecs[1] = '{1'b0, 1,  48'h79AED9DBC9E5, 4'd1};
        vecs[2] = '{1'b0, 14, 48'hBF918D3D3F0A, 4'd14};
        vecs[3] = '{1'b0, 15, 48'hCB3D8B0E17F5, 4'd15};
        vecs[4] = '{1'b1, 0,  48'hCB3D8B0E17F5, 4'd15};
        vecs[5] = '{1'b1, 1,  48'hBF918D3D3F0A, 4'd14};
        vecs[6] = '{1'b1, 14, 48'h79AED9DBC9E5, 4'd1};
        vecs[7] = '{1'b1, 15, 48'h1B02EFFC7072, 4'd0};

        rst_n = 1'b0;
        key_in = '0;
        decrypt = 1'b0;
        start = 1'b0;
        subkey_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", {63'd0, subkey_valid}, 64'd0);
        check("reset_subkey", {16'd0, subkey}, 64'd0);
        check("reset_round", {60'd0, round_idx}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sched(KEY_A, 1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin enc_sk[i] = del_sk[i]; enc_ri[i] = del_ri[i]; end
        run_sched(KEY_A, 1'b1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin dec_sk[i] = del_sk[i]; dec_ri[i] = del_ri[i]; end
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].dec) begin
                check("kat_dec_subkey", {16'd0, dec_sk[vecs[v].pos]}, {16'd0, vecs[v].exp_sk});
                check("kat_dec_round", {60'd0, dec_ri[vecs[v].pos]}, {60'd0, vecs[v].exp_ri});
            end else begin
                check("kat_enc_subkey", {16'd0, enc_sk[vecs[v].pos]}, {16'd0, vecs[v].exp_sk});
                check("kat_enc_round", {60'd0, enc_ri[vecs[v].pos]}, {60'd0, vecs[v].exp_ri});
            end
        end

        run_sched(KEY_A, 1'b0, 1, 0, 0);
        run_sched(KEY_A, 1'b1, 1, 0, 0);
        run_sched(KEY_A, 1'b0, 0, 0, 1);

        // Back-to-back: start stays high through done.
        run_sched(KEY_A, 1'b0, 0, 1, 0);
        run_sched(KEY_A, 1'b0, 0, 0, 0);
        check("b2b_first_subkey", {16'd0, del_sk[0]}, 64'h1B02EFFC7072);

        // Asynchronous reset mid-schedule at round 5.
        key_in = KEY_A;
        decrypt = 1'b0;
        start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (round_idx != 4'd5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round5", {60'd0, round_idx}, 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, subkey_valid}, 64'd0);
        check("arst_subkey", {16'd0, subkey}, 64'd0);
        check("arst_round", {60'd0, round_idx}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("arst_no_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_sched(KEY_A, 1'b1, 0, 0, 0);
        check("post_reset_first", {16'd0, del_sk[0]}, 64'hCB3D8B0E17F5);

        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom};
            rdec = 1'($urandom_range(0, 1));
            run_sched(rkey, rdec, 2, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
# des_key_scheduler

Sequential DES key schedule that turns one 64-bit key into the 16 48-bit round subkeys, delivering one subkey per accepted handshake in either encryption order (K1..K16) or decryption order (K16..K1). It sits directly upstream of the iterative Feistel round engine of the DES encrypt/decrypt datapath and replaces the fully-unrolled 16-output subkey generator wherever round keys are consumed one round per cycle. It uses the same DES bit numbering: bit 1 is the MSB.

## Interface

Parameters: none. PC-1, PC-2 and the shift schedule are fixed FIPS 46-3 constants.

Ports:
- clk  input  1  — single clock, rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- key_in  input  [64:1]  — DES key. Parity bits 8,16,…,64 are ignored by PC-1.
- decrypt  input  1  — sampled with start. 0 selects order K1..K16; 1 selects order K16..K1.
- start  input  1  — request a new schedule. Accepted only in IDLE.
- subkey_valid  output  1  — subkey holds a valid round key.
- subkey_ready  input  1  — downstream consumer accepts the subkey.
- subkey  output  [48:1]  — PC-2(C,D) of the current C/D registers.
- round_idx  output  [4:1]  — DES round number of the current subkey minus 1. K1 is 0 and K16 is 15, independent of order.
- busy  output  1  — high in GEN state.
- done  output  1  — one-cycle pulse after the 16th subkey is accepted.

## Operation

- State: 2-state FSM IDLE/GEN; C,D registers (28 bits each); 4-bit step counter `step`; mode flag `dec_q`.
- IDLE, start=1: load {C,D} ← PC-1(key_in), `dec_q` ← decrypt, step ← 0, go to GEN. start=0: remain in IDLE.
- GEN: subkey_valid=1. subkey = PC-2(C_cur,D_cur), where the current C/D already includes that round's shift.
  - Encrypt: the load applies PC-1, then rotates left by shift[1]=1. K1 is therefore available in the first GEN cycle.
  - Shift schedule, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: the load applies PC-1 with no rotate, which gives K16 (total rotation is 28).
  - Decrypt handshake k (k=1..15): C,D rotate right by shift[17−k]. That gives 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Handshake (subkey_valid & subkey_ready):
  - Encrypt: C,D rotate left by shift[step+2].
  - step ← step+1.
  - On the handshake at step=15: go to IDLE, with done=1 in the next cycle.
- round_idx = step when encrypting; 15−step when decrypting.
- Stall: with subkey_valid=1 and subkey_ready=0, the subkey, round_idx and all registers hold unchanged.
- start in GEN is ignored. key_in and decrypt are only sampled at acceptance.
- Mid-operation rst_n low: immediately IDLE. All registers clear; no done pulse.

## Timing

- Reset values: subkey_valid=0, subkey=0 (C=D=0 maps to 0), round_idx=0, busy=0, done=0, step=0.
- start sampled high in IDLE at edge t:
  - subkey_valid=1 and busy=1 from cycle t+1. The first subkey has 1-cycle latency.
- subkey_ready held high: one subkey per cycle during cycles t+1..t+16.
- After the final handshake: subkey_valid=0 and busy=0 at t+17, with done=1 for exactly that cycle.
- A start at t+17 is accepted (state is IDLE). done and the new load coincide, and subkey_valid rises at t+18.
- Each stall cycle adds exactly one cycle of latency. No subkey is dropped or duplicated.
- subkey is registered-path only: combinational PC-2 of the C/D flops. There is no combinational path from subkey_ready or key_in to subkey.

## Test plan

- Key 133457799BBCDFF1, decrypt=0, subkey_ready=1:
  - round_idx 0..15 across cycles t+1..t+16.
  - First subkey 1B02EFFC7072, second 79AED9DBC9E5, 15th BF918D3D3F0A, 16th CB3D8B0E17F5.
  - done=1 at t+17 only.
- Same key, decrypt=1:
  - First subkey CB3D8B0E17F5 (round_idx 15), then BF918D3D3F0A, …, 79AED9DBC9E5, last 1B02EFFC7072 (round_idx 0).
  - All 16 outputs equal the encrypt sequence reversed.
- Backpressure: subkey_ready pattern 1,0,0,1,0,1… → every subkey held stable while stalled. Exactly 16 handshakes in the correct order; done one cycle after the 16th.
- start pulsed during GEN with a different key → ignored, and the original sequence completes unchanged.
- rst_n low at round_idx 5 → all outputs 0 asynchronously. After release, a new start with decrypt=1 yields CB3D8B0E17F5 first.
- Back-to-back: start held high through done → second schedule begins with subkey_valid at t+18, with no gap error and the correct K1.
